// File: rtl/hex_scan_pkg.sv
// Shared constants and helpers for the hex_scan_n multi-digit 7-segment scan driver.
package hex_scan_pkg;

    typedef logic [7:0] seg_t;

    localparam int MAX_DIGITS = 16;

    // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic seg_t seg_apply(input seg_t raw, input bit active_low);
        return active_low ? ~raw : raw;
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble + decimal point to 8-bit segment pattern, board polarity applied.
module hex_seg_decode
    import hex_scan_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = seg_apply({dp, SEG_TABLE[nibble]}, ACTIVE_LOW);

endmodule

// File: rtl/hex_scan_n.sv
// Parametrised 7-segment scan driver: frame-coherent snapshot, leading-zero blanking,
// per-digit enable and anti-ghosting blank interval at the start of each slot.
module hex_scan_n
    import hex_scan_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int CLK_HZ         = 50_000_000,
    parameter int SLOT_HZ        = 1000,
    parameter int BLANK_CYC      = 100,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  En,
    input  logic [4*DIGITS-1:0]   Disp_data,
    input  logic [DIGITS-1:0]     Dp,
    input  logic [DIGITS-1:0]     Digit_en,
    input  logic                  Lz_blank,
    output logic [DIGITS-1:0]     Sel,
    output logic [7:0]            Seg,
    output logic                  Frame_done
);

    localparam int DIV   = CLK_HZ / SLOT_HZ;
    localparam int CNT_W = width_of(DIV);
    localparam int IDX_W = width_of(DIGITS);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_OFF   = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]        SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] data_sh;
    logic [DIGITS-1:0]   dp_sh;
    logic [DIGITS-1:0]   den_sh;
    logic                lz_sh;

    logic [DIGITS-1:0]   lz_mask;
    logic                zero_above;
    logic [3:0]          nib_p0;
    logic                dp_p0;
    logic                show_p0;
    logic [DIGITS-1:0]   sel_on_p0;
    logic [7:0]          seg_dec_p0;

    // A digit is blanked when it and every digit above it carry zero and no dp
    always_comb begin
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (data_sh[4*i +: 4] == 4'h0) && !dp_sh[i];
            lz_mask[i] = lz_sh && zero_above;
        end
    end

    always_comb begin
        nib_p0    = 4'h0;
        dp_p0     = 1'b0;
        show_p0   = 1'b0;
        sel_on_p0 = SEL_OFF;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_p0       = data_sh[4*i +: 4];
                dp_p0        = dp_sh[i];
                show_p0      = den_sh[i] && !lz_mask[i];
                sel_on_p0[i] = ~SEL_OFF[i];
            end
        end
    end

    hex_seg_decode #(
        .ACTIVE_LOW (SEG_ACTIVE_LOW != 0)
    ) u_dec (
        .nibble (nib_p0),
        .dp     (dp_p0),
        .seg    (seg_dec_p0)
    );

    // p0 -> p1: scan position and muxed digit registered onto the pins
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt        <= '0;
            idx        <= '0;
            data_sh    <= '0;
            dp_sh      <= '0;
            den_sh     <= '0;
            lz_sh      <= 1'b0;
            Sel        <= SEL_OFF;
            Seg        <= SEG_OFF;
            Frame_done <= 1'b0;
        end else if (!En) begin
            cnt        <= '0;
            idx        <= '0;
            Sel        <= SEL_OFF;
            Seg        <= SEG_OFF;
            Frame_done <= 1'b0;
        end else begin
            if (cnt == '0 && idx == '0) begin
                data_sh <= Disp_data;
                dp_sh   <= Dp;
                den_sh  <= Digit_en;
                lz_sh   <= Lz_blank;
            end
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            Frame_done <= (cnt == CNT_LAST) && (idx == IDX_LAST);
            if (cnt >= CNT_BLANK && show_p0) begin
                Sel <= sel_on_p0;
                Seg <= seg_dec_p0;
            end else begin
                Sel <= SEL_OFF;
                Seg <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_n.sv
// Randomized bench for hex_scan_n against a frame/slot-position reference model.
module tb_hex_scan_n;

    localparam int DIGITS = 8;
    localparam int DIV    = 10;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIV * DIGITS;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        En = 1'b0;
    logic [31:0] Disp_data = '0;
    logic [7:0]  Dp = '0;
    logic [7:0]  Digit_en = 8'hFF;
    logic        Lz_blank = 1'b0;
    logic [7:0]  Sel;
    logic [7:0]  Seg;
    logic        Frame_done;

    hex_scan_n #(
        .DIGITS         (DIGITS),
        .CLK_HZ         (10_000),
        .SLOT_HZ        (1000),
        .BLANK_CYC      (BLANK),
        .SEL_ACTIVE_LOW (1),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .En         (En),
        .Disp_data  (Disp_data),
        .Dp         (Dp),
        .Digit_en   (Digit_en),
        .Lz_blank   (Lz_blank),
        .Sel        (Sel),
        .Seg        (Seg),
        .Frame_done (Frame_done)
    );

    always #5 Clk = ~Clk;

    logic [6:0] seg_ref [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int errors = 0;
    int checks = 0;

    // Model: scan position since En rose, plus the copy of inputs taken at each frame start
    int          pos = 0;
    int          cur_p;
    logic [31:0] m_data = '0;
    logic [7:0]  m_dp = '0;
    logic [7:0]  m_den = '0;
    logic        m_lz = 1'b0;
    logic [7:0]  exp_sel;
    logic [7:0]  exp_seg;
    logic        exp_fd;

    function automatic bit blanked(input int d);
        return d > 0 && m_lz && (m_data >> (4 * d)) == 32'd0 && (m_dp >> d) == 8'd0;
    endfunction

    task automatic tick();
        bit         en_edge;
        int         slot;
        int         off;
        logic [3:0] nib;
        en_edge = En;
        if (en_edge && (pos % FRAME) == 0) begin
            m_data = Disp_data;
            m_dp   = Dp;
            m_den  = Digit_en;
            m_lz   = Lz_blank;
        end
        @(posedge Clk);
        #1;
        exp_sel = 8'hFF;
        exp_seg = 8'hFF;
        exp_fd  = 1'b0;
        cur_p   = pos;
        if (en_edge) begin
            slot   = (pos / DIV) % DIGITS;
            off    = pos % DIV;
            exp_fd = (pos % FRAME) == FRAME - 1;
            if (off >= BLANK && m_den[slot] && !blanked(slot)) begin
                nib     = 4'((m_data >> (4 * slot)) & 32'hF);
                exp_sel = ~(8'd1 << slot);
                exp_seg = ~{m_dp[slot], seg_ref[nib]};
            end
            pos++;
        end else begin
            pos = 0;
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        En = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({Sel, Seg, Frame_done} !== {8'hFF, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL reset: got sel=%h seg=%h fd=%b want sel=ff seg=ff fd=0", Sel, Seg, Frame_done);
        end
        Reset_n = 1'b1;
        pos = 0;
    endtask

    task automatic test_basic_scan();
        Disp_data = 32'h12345678;
        Dp = 8'h00;
        Digit_en = 8'hFF;
        Lz_blank = 1'b0;
        En = 1'b1;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            checks++;
            if ({Sel, Seg, Frame_done} !== {exp_sel, exp_seg, exp_fd}) begin
                errors++;
                $display("FAIL basic_scan p=%0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                         cur_p, Sel, Seg, Frame_done, exp_sel, exp_seg, exp_fd);
            end
            if (cur_p == 2 || cur_p == 72) begin
                checks++;
                if ({Sel, Seg} !== ((cur_p == 2) ? 16'hFE80 : 16'h7FF9)) begin
                    errors++;
                    $display("FAIL basic_slot p=%0d: got sel=%h seg=%h", cur_p, Sel, Seg);
                end
            end
        end
    endtask

    task automatic test_lz_blank();
        Disp_data = 32'h0000_00A0;
        Lz_blank = 1'b1;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            checks++;
            if ({Sel, Seg, Frame_done} !== {exp_sel, exp_seg, exp_fd}) begin
                errors++;
                $display("FAIL lz_blank p=%0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                         cur_p, Sel, Seg, Frame_done, exp_sel, exp_seg, exp_fd);
            end
        end
        Dp = 8'h20;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            checks++;
            if ({Sel, Seg, Frame_done} !== {exp_sel, exp_seg, exp_fd}) begin
                errors++;
                $display("FAIL lz_dp p=%0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                         cur_p, Sel, Seg, Frame_done, exp_sel, exp_seg, exp_fd);
            end
            if (m_dp == 8'h20 && (cur_p % FRAME) == 52) begin
                checks++;
                if ({Sel, Seg} !== 16'hDF40) begin
                    errors++;
                    $display("FAIL lz_dp_slot5: got sel=%h seg=%h want sel=df seg=40", Sel, Seg);
                end
            end
        end
        Dp = 8'h00;
        Lz_blank = 1'b0;
    endtask

    task automatic test_midframe_change();
        while ((pos % FRAME) != 3 * DIV) begin
            tick();
            checks++;
            if ({Sel, Seg, Frame_done} !== {exp_sel, exp_seg, exp_fd}) begin
                errors++;
                $display("FAIL midframe_pre p=%0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                         cur_p, Sel, Seg, Frame_done, exp_sel, exp_seg, exp_fd);
            end
        end
        Disp_data = $urandom;
        for (int k = 0; k < FRAME + 50; k++) begin
            tick();
            checks++;
            if ({Sel, Seg, Frame_done} !== {exp_sel, exp_seg, exp_fd}) begin
                errors++;
                $display("FAIL midframe p=%0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                         cur_p, Sel, Seg, Frame_done, exp_sel, exp_seg, exp_fd);
            end
        end
    endtask

    task automatic test_digit_en();
        int pulses;
        int last_pulse;
        pulses = 0;
        last_pulse = -1;
        Digit_en = 8'hF0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            checks++;
            if ({Sel, Seg, Frame_done} !== {exp_sel, exp_seg, exp_fd}) begin
                errors++;
                $display("FAIL digit_en p=%0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                         cur_p, Sel, Seg, Frame_done, exp_sel, exp_seg, exp_fd);
            end
            if (Frame_done === 1'b1) begin
                if (last_pulse >= 0) begin
                    checks++;
                    if (k - last_pulse != FRAME) begin
                        errors++;
                        $display("FAIL frame_period: got %0d want %0d", k - last_pulse, FRAME);
                    end
                end
                last_pulse = k;
                pulses++;
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL frame_pulses: got %0d want 2", pulses);
        end
        Digit_en = 8'hFF;
    endtask

    task automatic test_en_drop();
        while ((pos % FRAME) != 4 * DIV + 5) begin
            tick();
            checks++;
            if ({Sel, Seg, Frame_done} !== {exp_sel, exp_seg, exp_fd}) begin
                errors++;
                $display("FAIL en_drop_pre p=%0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                         cur_p, Sel, Seg, Frame_done, exp_sel, exp_seg, exp_fd);
            end
        end
        En = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({Sel, Seg, Frame_done} !== {8'hFF, 8'hFF, 1'b0}) begin
                errors++;
                $display("FAIL en_low k=%0d: got sel=%h seg=%h fd=%b want sel=ff seg=ff fd=0",
                         k, Sel, Seg, Frame_done);
            end
        end
        En = 1'b1;
        Disp_data = $urandom;
        Dp = 8'($urandom);
        for (int k = 0; k < FRAME + 20; k++) begin
            tick();
            checks++;
            if ({Sel, Seg, Frame_done} !== {exp_sel, exp_seg, exp_fd}) begin
                errors++;
                $display("FAIL en_restart p=%0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                         cur_p, Sel, Seg, Frame_done, exp_sel, exp_seg, exp_fd);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6 * FRAME; k++) begin
            if ($urandom_range(0, 29) == 0) begin
                Disp_data = $urandom;
                if ($urandom_range(0, 1) == 1) Disp_data = Disp_data >> (4 * $urandom_range(1, 7));
                Dp       = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
                Digit_en = 8'($urandom);
                Lz_blank = 1'($urandom);
            end
            tick();
            checks++;
            if ({Sel, Seg, Frame_done} !== {exp_sel, exp_seg, exp_fd}) begin
                errors++;
                $display("FAIL random p=%0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                         cur_p, Sel, Seg, Frame_done, exp_sel, exp_seg, exp_fd);
            end
        end
        Digit_en = 8'hFF;
        Lz_blank = 1'b0;
        Dp = 8'h00;
    endtask

    task automatic test_async_reset();
        int guard;
        guard = 0;
        Disp_data = 32'h9ABC_DEF1;
        while (Frame_done !== 1'b1 && guard < 3 * FRAME) begin
            tick();
            guard++;
        end
        checks++;
        if (Frame_done !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_setup: no frame_done within %0d cycles", guard);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({Sel, Seg, Frame_done} !== {8'hFF, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got sel=%h seg=%h fd=%b want sel=ff seg=ff fd=0", Sel, Seg, Frame_done);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        pos = 0;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            checks++;
            if ({Sel, Seg, Frame_done} !== {exp_sel, exp_seg, exp_fd}) begin
                errors++;
                $display("FAIL after_reset p=%0d: got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                         cur_p, Sel, Seg, Frame_done, exp_sel, exp_seg, exp_fd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_lz_blank();
        test_midframe_change();
        test_digit_en();
        test_en_drop();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hex_scan_n.md
Name: hex_scan_n

Overview:
Parametrised multi-digit 7-segment scan driver, successor to the fixed 8-digit hex8 driver. It time-multiplexes DIGITS hex nibbles onto one shared segment bus plus a one-hot digit-select bus. Beyond hex8 it adds:
- per-digit decimal points and a per-digit enable mask
- optional leading-zero blanking
- an anti-ghosting blank interval at the start of every digit slot
- frame-coherent snapshot of the display data, and a frame-done pulse
It sits between application logic and the board's digit/segment pins.

Parameters:
DIGITS, 8, number of digits scanned (1..16)
CLK_HZ, 50_000_000, input clock frequency in Hz
SLOT_HZ, 1000, digit slot rate; slot length DIV = CLK_HZ/SLOT_HZ cycles
BLANK_CYC, 100, cycles at slot start with all outputs inactive; legal range 1 <= BLANK_CYC < DIV
SEL_ACTIVE_LOW, 1, 1 = Sel bits active low
SEG_ACTIVE_LOW, 1, 1 = Seg bits active low (common-anode)

Ports:
Clk  in  1  system clock, rising-edge
Reset_n  in  1  asynchronous active-low reset
En  in  1  scan enable; low = display dark and scan held at start
Disp_data  in  4*DIGITS  nibble i = hex value of digit i (digit 0 = least significant)
Dp  in  DIGITS  bit i lights the decimal point of digit i
Digit_en  in  DIGITS  bit i = 0 keeps digit i dark (its slot time is still spent)
Lz_blank  in  1  1 = blank leading zeros
Sel  out  DIGITS  one-hot digit select, polarity per SEL_ACTIVE_LOW
Seg  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
Frame_done  out  1  one-cycle pulse at the end of each full scan frame

Behaviour:
- Reset (async assert, sync release on Clk):
  - slot counter cnt = 0, digit index idx = 0, shadow registers = 0
  - Sel and Seg all inactive (all 1s when the active-low parameter is set)
  - Frame_done = 0
- cnt counts 0..DIV-1 while En = 1. At cnt = DIV-1, cnt wraps to 0 and idx advances; idx wraps from DIGITS-1 to 0.
- Snapshot: on the edge where En = 1, cnt = 0 and idx = 0, capture Disp_data, Dp, Digit_en and Lz_blank into shadow registers. Mid-frame input changes are ignored until the next frame.
- Leading-zero mask, computed from the shadow copy: digit i (i > 0) is blanked when all of the following hold:
  - Lz_blank is set
  - nibbles i..DIGITS-1 are all 0
  - Dp bits i..DIGITS-1 are all 0
  Digit 0 is never blanked.
- Sel and Seg are registered, one-cycle latency from cnt/idx.
  - When cnt < BLANK_CYC: both buses are inactive.
  - Otherwise, if digit idx is enabled and not blanked: Sel has bit idx active and Seg = decode(nibble idx) with dp = Dp[idx].
  - Otherwise: both buses stay inactive.
- Decode table, active-high {g..a}:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - SEG_ACTIVE_LOW inverts all 8 bits.
- Frame_done: registered pulse, high for one cycle after the edge where idx = DIGITS-1 and cnt = DIV-1 with En = 1.
- En = 0:
  - cnt and idx are cleared to 0 synchronously, outputs go inactive, Frame_done = 0
  - the shadow registers hold their values
  - when En rises, a new frame starts at digit 0 with a fresh snapshot
- Because BLANK_CYC >= 1, a snapshot taken at cnt = 0 is never displayed mid-slot.
- DIGITS = 1: idx is constant 0 and Frame_done pulses once per slot.

Decomposition:
- Package hex_scan_pkg:
  - 16-entry segment constant table
  - segment/polarity helper function
  - clog2-based width constants for cnt and idx
- Sub-module hex_seg_decode: combinational, 4-bit nibble + dp + polarity in, 8-bit Seg out. It is instantiated once on the muxed shadow nibble.

Test Plan:
(Bench overrides: DIV = 10, BLANK_CYC = 2, active-low polarity.)
- Reset, then DIGITS = 8, Disp_data = 32'h12345678, Dp = 0, Digit_en = FF, Lz_blank = 0:
  - slot 0: Sel = 8'hFE, Seg = 8'h80
  - slot 7: Sel = 8'h7F, Seg = 8'hF9
  - first two cycles of each slot: Sel = 8'hFF and Seg = 8'hFF
- Disp_data = 32'h0000_00A0, Lz_blank = 1:
  - slots 2..7 dark (Sel = FF)
  - slot 1 Seg = 8'h88 (A)
  - slot 0 Seg = 8'hC0 (0)
  - Dp[5] = 1 lights slots 5..0 and slot 5 Seg = 8'h40
- Change Disp_data at mid-frame (slot 3): the remaining slots show the old data; the new data appears from the next slot 0.
- Digit_en = 8'hF0: slots 0..3 dark, frame period unchanged (80 cycles); Frame_done pulses exactly once per 80 cycles.
- Drop En during slot 4, raise it 5 cycles later: outputs inactive meanwhile; scan restarts at slot 0 with a fresh snapshot.
- Assert Reset_n low mid-slot, asynchronously (between edges): Sel = FF, Seg = FF and Frame_done = 0 immediately, without waiting for Clk.
